// File: rtl/nap_pkg.sv
// Shared types and constants for the nap countdown: state encoding, BCD digit
// limits and the packed six-digit time used by both the setter and countdown.
package nap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } nap_state_t;

    localparam logic [3:0] LIM_9 = 4'd9;
    localparam logic [3:0] LIM_5 = 4'd5;

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    localparam bcd_time_t BCD_MAX_TIME = 24'h99_59_59;
    localparam bcd_time_t BCD_ONE_SEC  = 24'h00_00_01;
    localparam bcd_time_t BCD_ZERO     = 24'h00_00_00;

    // Any out-of-range digit makes the whole entry untrustworthy, so clamp to max.
    function automatic bcd_time_t bcd_saturate(input bcd_time_t t);
        if (t.h10 > LIM_9 || t.h1 > LIM_9 || t.m10 > LIM_5 ||
            t.m1 > LIM_9 || t.s10 > LIM_5 || t.s1 > LIM_9)
            return BCD_MAX_TIME;
        return t;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown: loadable register that decrements on an
// incoming borrow and wraps to LIMIT, passing the borrow up the chain.
module bcd_digit_dec #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] load_value,
    input  logic       load,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out
);

    assign borrow_out = dec && borrow_in && (value == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && borrow_in) begin
            value <= (value == 4'd0) ? LIMIT : value - 4'd1;
        end
    end

endmodule

// File: rtl/nap_countdown.sv
// Nap timer: loads a BCD duration, counts it down on the 1 Hz tick and holds
// the wake alarm until dismissed or ALARM_TICKS ticks have elapsed.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a load; digits hold their last value
// ST_RUN   | decrementing one second per tick
// ST_PAUSE | countdown frozen while pause is high
// ST_ALARM | digits at zero, alarm high, counting ticks toward timeout
module nap_countdown
    import nap_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [3:0] hour10,
    input  logic [3:0] hour1,
    input  logic [3:0] minute10,
    input  logic [3:0] minute1,
    input  logic [3:0] second10,
    input  logic [3:0] second1,
    input  logic       pause,
    input  logic       cancel,
    output logic [3:0] rHour10,
    output logic [3:0] rHour1,
    output logic [3:0] rMinute10,
    output logic [3:0] rMinute1,
    output logic [3:0] rSecond10,
    output logic [3:0] rSecond1,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS);

    nap_state_t state_q, state_d;
    logic [7:0] acnt_q, acnt_d;
    logic       done_q, done_d;

    bcd_time_t  load_val;
    bcd_time_t  cur_time;
    bcd_time_t  dig_load_val;
    logic       dig_load;
    logic       dig_dec;
    logic [5:0] borrow;
    logic       unused_borrow_top;

    assign load_val = bcd_saturate({hour10, hour1, minute10, minute1, second10, second1});

    always_comb begin
        state_d      = state_q;
        acnt_d       = acnt_q;
        dig_load     = 1'b0;
        dig_load_val = load_val;
        dig_dec      = 1'b0;

        if (cancel) begin
            // Cancel always swallows a same-cycle load; in IDLE it is a no-op.
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                acnt_d  = 8'd0;
                if (state_q != ST_ALARM) begin
                    dig_load     = 1'b1;
                    dig_load_val = BCD_ZERO;
                end
            end
        end else if (load) begin
            dig_load = 1'b1;
            acnt_d   = 8'd0;
            state_d  = (load_val == BCD_ZERO) ? ST_IDLE : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick_1hz) begin
                        dig_dec = 1'b1;
                        if (cur_time == BCD_ONE_SEC) begin
                            state_d = ST_ALARM;
                            acnt_d  = 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_d = ST_RUN;
                end
                ST_ALARM: begin
                    if (tick_1hz) begin
                        if (acnt_q + 8'd1 == ALARM_LAST) begin
                            state_d = ST_IDLE;
                            acnt_d  = 8'd0;
                        end else begin
                            acnt_d = acnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        done_d = (state_d == ST_ALARM) && (state_q != ST_ALARM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acnt_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            done_q  <= done_d;
        end
    end

    // Borrow chain runs from seconds-units up to hours-tens.
    bcd_digit_dec #(.LIMIT(LIM_9)) u_s1 (
        .clock(clock), .reset(reset), .load_value(dig_load_val.s1), .load(dig_load),
        .dec(dig_dec), .borrow_in(1'b1), .value(cur_time.s1), .borrow_out(borrow[0])
    );
    bcd_digit_dec #(.LIMIT(LIM_5)) u_s10 (
        .clock(clock), .reset(reset), .load_value(dig_load_val.s10), .load(dig_load),
        .dec(dig_dec), .borrow_in(borrow[0]), .value(cur_time.s10), .borrow_out(borrow[1])
    );
    bcd_digit_dec #(.LIMIT(LIM_9)) u_m1 (
        .clock(clock), .reset(reset), .load_value(dig_load_val.m1), .load(dig_load),
        .dec(dig_dec), .borrow_in(borrow[1]), .value(cur_time.m1), .borrow_out(borrow[2])
    );
    bcd_digit_dec #(.LIMIT(LIM_5)) u_m10 (
        .clock(clock), .reset(reset), .load_value(dig_load_val.m10), .load(dig_load),
        .dec(dig_dec), .borrow_in(borrow[2]), .value(cur_time.m10), .borrow_out(borrow[3])
    );
    bcd_digit_dec #(.LIMIT(LIM_9)) u_h1 (
        .clock(clock), .reset(reset), .load_value(dig_load_val.h1), .load(dig_load),
        .dec(dig_dec), .borrow_in(borrow[3]), .value(cur_time.h1), .borrow_out(borrow[4])
    );
    bcd_digit_dec #(.LIMIT(LIM_9)) u_h10 (
        .clock(clock), .reset(reset), .load_value(dig_load_val.h10), .load(dig_load),
        .dec(dig_dec), .borrow_in(borrow[4]), .value(cur_time.h10), .borrow_out(borrow[5])
    );

    // Expiry is caught at 00:00:01, so the top borrow can never fire.
    assign unused_borrow_top = borrow[5];

    assign rHour10   = cur_time.h10;
    assign rHour1    = cur_time.h1;
    assign rMinute10 = cur_time.m10;
    assign rMinute1  = cur_time.m1;
    assign rSecond10 = cur_time.s10;
    assign rSecond1  = cur_time.s1;
    assign running   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign alarm     = (state_q == ST_ALARM);
    assign done      = done_q;

endmodule
